// File: rtl/gtxe2_chnl_bond_pkg.sv
// Shared definitions for the multi-lane RX channel-bonding block:
// FSM state encodings, K-character constants and the pointer-width helper.
package gtxe2_chnl_bond_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_BONDED = 2'd3
  } bond_state_t;

  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_5 = 8'hBC;

  // Pointer / skew field width for a buffer of the given depth.
  function automatic int skw_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/gtxe2_chnl_bond_lane.sv
// One bonded lane: circular skew buffer, bonding-marker detect on the write
// and read sides, and the captured read pointer / arrival offset.
module gtxe2_chnl_bond_lane
  import gtxe2_chnl_bond_pkg::*;
#(
  parameter int          DATA_BYTES = 2,
  parameter int          SKEW_DEPTH = 8,
  parameter logic [7:0]  BOND_CHAR  = K28_3,
  localparam int         SKW        = skw_width(SKEW_DEPTH),
  localparam int         LW         = DATA_BYTES * 8
) (
  input  logic                  RXUSRCLK2,
  input  logic                  reset_n,
  input  logic                  valid,
  input  logic [LW-1:0]         data,
  input  logic [DATA_BYTES-1:0] charisk,
  input  logic [SKW-1:0]        wptr,
  input  logic                  capture,
  input  logic [SKW-1:0]        arr_val,
  input  logic                  advance,
  output logic                  marker,
  output logic                  rd_marker,
  output logic [LW-1:0]         rd_data,
  output logic [DATA_BYTES-1:0] rd_charisk,
  output logic [SKW-1:0]        arrival
);

  logic [LW+DATA_BYTES-1:0] buffer [SKEW_DEPTH];
  logic [SKW-1:0]           rptr;

  // The buffer is written every cycle so that a captured pointer always
  // lands on the marker word, regardless of the bonding state.
  always_ff @(posedge RXUSRCLK2) begin
    buffer[wptr] <= {charisk, data};
  end

  assign marker = valid && charisk[0] && (data[7:0] == BOND_CHAR);

  assign {rd_charisk, rd_data} = buffer[rptr];
  assign rd_marker = rd_charisk[0] && (rd_data[7:0] == BOND_CHAR);

  always_ff @(posedge RXUSRCLK2 or negedge reset_n) begin
    if (!reset_n) begin
      rptr    <= '0;
      arrival <= '0;
    end else if (capture) begin
      rptr    <= wptr;
      arrival <= arr_val;
    end else if (advance) begin
      rptr    <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/gtxe2_chnl_bond.sv
// Multi-lane RX deskew: finds the bonding marker in every lane, then re-times
// all lanes from their per-lane buffers into one aligned wide word stream.
module gtxe2_chnl_bond
  import gtxe2_chnl_bond_pkg::*;
#(
  parameter int          LANES      = 4,
  parameter int          DATA_BYTES = 2,
  parameter int          SKEW_DEPTH = 8,
  parameter logic [7:0]  BOND_CHAR  = K28_3,
  localparam int         SKW        = skw_width(SKEW_DEPTH),
  localparam int         LW         = DATA_BYTES * 8
) (
  input  logic                        RXUSRCLK2,
  input  logic                        reset_n,
  input  logic                        bond_en,
  input  logic [LANES-1:0]            in_valid,
  input  logic [LANES*LW-1:0]         in_data,
  input  logic [LANES*DATA_BYTES-1:0] in_charisk,
  output logic                        out_valid,
  output logic [LANES*LW-1:0]         out_data,
  output logic [LANES*DATA_BYTES-1:0] out_charisk,
  output logic                        bonded,
  output logic                        bond_err,
  output logic [LANES*SKW-1:0]        lane_skew
);

  localparam logic [SKW-1:0] CNT_LIMIT = SKW'(SKEW_DEPTH - 2);

  bond_state_t                 state;
  logic [SKW-1:0]              wptr;
  logic [SKW-1:0]              cnt;
  logic [SKW-1:0]              arr_val;
  logic [LANES-1:0]            captured;
  logic [LANES-1:0]            mark;
  logic [LANES-1:0]            rd_mark;
  logic [LANES-1:0]            capture;
  logic                        advance;
  logic                        wait_err;
  logic                        bond_loss;
  logic [LANES*LW-1:0]         rd_data;
  logic [LANES*DATA_BYTES-1:0] rd_charisk;
  logic [LANES*SKW-1:0]        arrival;
  logic [LANES*SKW-1:0]        skew_next;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    gtxe2_chnl_bond_lane #(
      .DATA_BYTES (DATA_BYTES),
      .SKEW_DEPTH (SKEW_DEPTH),
      .BOND_CHAR  (BOND_CHAR)
    ) u_lane (
      .RXUSRCLK2  (RXUSRCLK2),
      .reset_n    (reset_n),
      .valid      (in_valid[g]),
      .data       (in_data[g*LW +: LW]),
      .charisk    (in_charisk[g*DATA_BYTES +: DATA_BYTES]),
      .wptr       (wptr),
      .capture    (capture[g]),
      .arr_val    (arr_val),
      .advance    (advance),
      .marker     (mark[g]),
      .rd_marker  (rd_mark[g]),
      .rd_data    (rd_data[g*LW +: LW]),
      .rd_charisk (rd_charisk[g*DATA_BYTES +: DATA_BYTES]),
      .arrival    (arrival[g*SKW +: SKW])
    );
    assign skew_next[g*SKW +: SKW] = capture[g] ? arr_val : arrival[g*SKW +: SKW];
  end

  // A lane still missing at the window limit would need an offset beyond
  // what the buffer can absorb, so that case is treated as a failure.
  assign wait_err  = !(&in_valid) || (|(captured & mark)) ||
                     ((cnt == CNT_LIMIT) && !(&captured));
  assign bond_loss = !(&in_valid) || ((|rd_mark) && !(&rd_mark));
  assign advance   = bond_en && (state == ST_BONDED) && !bond_loss;
  assign bonded    = (state == ST_BONDED);

  always_comb begin
    capture = '0;
    arr_val = '0;
    if (bond_en) begin
      if (state == ST_SEARCH) begin
        capture = mark;
      end else if (state == ST_WAIT && !wait_err) begin
        capture = mark & ~captured;
        arr_val = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge RXUSRCLK2 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      wptr        <= '0;
      cnt         <= '0;
      captured    <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_charisk <= '0;
      bond_err    <= 1'b0;
      lane_skew   <= '0;
    end else begin
      wptr      <= wptr + 1'b1;
      bond_err  <= 1'b0;
      out_valid <= 1'b0;
      if (!bond_en) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: state <= ST_SEARCH;
          ST_SEARCH: begin
            cnt      <= '0;
            captured <= mark;
            if (|mark) state <= ST_WAIT;
          end
          ST_WAIT: begin
            cnt <= cnt + 1'b1;
            if (wait_err) begin
              bond_err <= 1'b1;
              state    <= ST_SEARCH;
            end else begin
              captured <= captured | mark;
              if (&(captured | mark)) begin
                state     <= ST_BONDED;
                lane_skew <= skew_next;
              end
            end
          end
          ST_BONDED: begin
            if (bond_loss) begin
              bond_err <= 1'b1;
              state    <= ST_SEARCH;
            end else begin
              out_valid   <= 1'b1;
              out_data    <= rd_data;
              out_charisk <= rd_charisk;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gtxe2_chnl_bond.sv
// Directed bench for gtxe2_chnl_bond: zero skew, skewed bond, disable,
// bond loss and rebond, partial marker, skew overflow and async reset.
module tb_gtxe2_chnl_bond;

  localparam int LANES      = 4;
  localparam int DATA_BYTES = 2;
  localparam int SKEW_DEPTH = 8;
  localparam int SKW        = 3;
  localparam int LW         = DATA_BYTES * 8;

  logic                        RXUSRCLK2 = 1'b0;
  logic                        reset_n;
  logic                        bond_en;
  logic [LANES-1:0]            in_valid;
  logic [LANES*LW-1:0]         in_data;
  logic [LANES*DATA_BYTES-1:0] in_charisk;
  logic                        out_valid;
  logic [LANES*LW-1:0]         out_data;
  logic [LANES*DATA_BYTES-1:0] out_charisk;
  logic                        bonded;
  logic                        bond_err;
  logic [LANES*SKW-1:0]        lane_skew;

  int               t;
  int               tests;
  int               failed;
  int               mk [LANES];
  logic [LANES-1:0] valid_mask;
  int               inj_lane;
  int               inj_t;

  gtxe2_chnl_bond #(
    .LANES      (LANES),
    .DATA_BYTES (DATA_BYTES),
    .SKEW_DEPTH (SKEW_DEPTH),
    .BOND_CHAR  (8'h7C)
  ) dut (
    .RXUSRCLK2   (RXUSRCLK2),
    .reset_n     (reset_n),
    .bond_en     (bond_en),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_charisk  (in_charisk),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_charisk (out_charisk),
    .bonded      (bonded),
    .bond_err    (bond_err),
    .lane_skew   (lane_skew)
  );

  always #5 RXUSRCLK2 = ~RXUSRCLK2;

  // Each lane carries a sequence number in byte 1 counted from its own marker,
  // so aligned output shows the same number in every lane.
  task automatic tick();
    logic [LW-1:0]         w;
    logic [DATA_BYTES-1:0] k;
    @(negedge RXUSRCLK2);
    t++;
    for (int l = 0; l < LANES; l++) begin
      if (mk[l] >= 0 && t == mk[l]) begin
        w = 16'h007C;
        k = 2'b01;
      end else if (mk[l] >= 0 && t > mk[l]) begin
        w = {8'(t - mk[l]), 8'h55};
        k = 2'b00;
      end else begin
        w = 16'hEE55;
        k = 2'b00;
      end
      if (l == inj_lane && t == inj_t) begin
        w[7:0] = 8'h7C;
        k[0]   = 1'b1;
      end
      in_data[l*LW +: LW]                   = w;
      in_charisk[l*DATA_BYTES +: DATA_BYTES] = k;
    end
    in_valid = valid_mask;
  endtask

  task automatic run_to(input int target);
    while (t < target) tick();
  endtask

  function automatic logic [63:0] exp_word(input int s);
    logic [63:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++)
      r[l*LW +: LW] = (s == 0) ? 16'h007C : {8'(s), 8'h55};
    return r;
  endfunction

  function automatic logic [63:0] exp_k(input int s);
    return (s == 0) ? 64'h55 : 64'h0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    t          = 0;
    tests      = 0;
    failed     = 0;
    mk         = '{-1, -1, -1, -1};
    inj_lane   = -1;
    inj_t      = -1;
    valid_mask = '1;
    reset_n    = 1'b0;
    bond_en    = 1'b0;
    in_valid   = '1;
    in_data    = '0;
    in_charisk = '0;

    // Reset state
    run_to(3);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_bonded", 64'(bonded), 64'd0);
    check("rst_bond_err", 64'(bond_err), 64'd0);
    check("rst_lane_skew", 64'(lane_skew), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    reset_n = 1'b1;
    bond_en = 1'b1;

    // Zero skew: all lanes mark in cycle 6
    mk = '{6, 6, 6, 6};
    run_to(7);
    check("zs_not_yet_bonded", 64'(bonded), 64'd0);
    run_to(8);
    check("zs_bonded", 64'(bonded), 64'd1);
    check("zs_lane_skew", 64'(lane_skew), 64'd0);
    check("zs_out_valid_lat", 64'(out_valid), 64'd0);
    run_to(9);
    check("zs_out_valid", 64'(out_valid), 64'd1);
    check("zs_word0", 64'(out_data), exp_word(0));
    check("zs_k0", 64'(out_charisk), exp_k(0));
    run_to(10);
    check("zs_word1", 64'(out_data), exp_word(1));
    run_to(11);
    check("zs_word2", 64'(out_data), exp_word(2));

    // Disable while bonded
    bond_en = 1'b0;
    run_to(12);
    check("dis_bonded", 64'(bonded), 64'd0);
    check("dis_out_valid", 64'(out_valid), 64'd0);
    check("dis_no_err", 64'(bond_err), 64'd0);
    bond_en = 1'b1;

    // Skewed lanes: offsets 0,1,3,4
    mk = '{15, 16, 18, 19};
    run_to(19);
    check("sk_not_yet_bonded", 64'(bonded), 64'd0);
    run_to(20);
    check("sk_bonded", 64'(bonded), 64'd1);
    check("sk_lane_skew", 64'(lane_skew), 64'h8C8);
    check("sk_out_valid_lat", 64'(out_valid), 64'd0);
    run_to(21);
    check("sk_out_valid", 64'(out_valid), 64'd1);
    check("sk_word0", 64'(out_data), exp_word(0));
    check("sk_k0", 64'(out_charisk), exp_k(0));
    run_to(22);
    check("sk_word1", 64'(out_data), exp_word(1));
    check("sk_k1", 64'(out_charisk), exp_k(1));
    run_to(23);
    check("sk_word2", 64'(out_data), exp_word(2));

    // Bond loss: lane 2 invalid for one cycle
    valid_mask = 4'b1011;
    run_to(24);
    check("loss_pre_word3", 64'(out_data), exp_word(3));
    check("loss_pre_valid", 64'(out_valid), 64'd1);
    valid_mask = '1;
    run_to(25);
    check("loss_err", 64'(bond_err), 64'd1);
    check("loss_bonded", 64'(bonded), 64'd0);
    check("loss_out_valid", 64'(out_valid), 64'd0);
    run_to(26);
    check("loss_err_pulse", 64'(bond_err), 64'd0);

    // Rebond with lanes 2,3 two words late
    mk = '{28, 28, 30, 30};
    run_to(30);
    check("rb_skew_held", 64'(lane_skew), 64'h8C8);
    check("rb_not_yet_bonded", 64'(bonded), 64'd0);
    run_to(31);
    check("rb_bonded", 64'(bonded), 64'd1);
    check("rb_lane_skew", 64'(lane_skew), 64'h480);
    run_to(32);
    check("rb_word0", 64'(out_data), exp_word(0));
    check("rb_k0", 64'(out_charisk), exp_k(0));
    run_to(33);
    check("rb_word1", 64'(out_data), exp_word(1));

    // Partial marker on lane 1 only
    inj_lane = 1;
    inj_t    = 34;
    run_to(34);
    check("pm_word2", 64'(out_data), exp_word(2));
    run_to(37);
    check("pm_word5", 64'(out_data), exp_word(5));
    check("pm_no_err_yet", 64'(bond_err), 64'd0);
    check("pm_still_bonded", 64'(bonded), 64'd1);
    run_to(38);
    check("pm_err", 64'(bond_err), 64'd1);
    check("pm_bonded", 64'(bonded), 64'd0);
    check("pm_out_valid", 64'(out_valid), 64'd0);

    // Skew overflow: lane 3 seven words after lane 0
    mk = '{40, 41, 41, 47};
    run_to(47);
    check("ov_no_err_yet", 64'(bond_err), 64'd0);
    check("ov_not_bonded", 64'(bonded), 64'd0);
    run_to(48);
    check("ov_err", 64'(bond_err), 64'd1);
    check("ov_bonded", 64'(bonded), 64'd0);
    run_to(49);
    check("ov_err_pulse", 64'(bond_err), 64'd0);
    check("ov_skew_held", 64'(lane_skew), 64'h480);

    // Asynchronous reset in the middle of WAIT
    mk = '{51, 54, 54, 54};
    run_to(52);
    check("ar_skew_before", 64'(lane_skew), 64'h480);
    reset_n = 1'b0;
    #1;
    check("ar_lane_skew", 64'(lane_skew), 64'd0);
    check("ar_out_data", 64'(out_data), 64'd0);
    check("ar_out_charisk", 64'(out_charisk), 64'd0);
    check("ar_out_valid", 64'(out_valid), 64'd0);
    check("ar_bonded", 64'(bonded), 64'd0);
    check("ar_bond_err", 64'(bond_err), 64'd0);
    run_to(54);
    reset_n = 1'b1;
    run_to(56);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
